// File: rtl/lbist_pkg.sv
// lbist_pkg
//   Shared definitions for the LBIST pattern sequencer slice.
//   - State encoding of the sequencer FSM (3 bits).
//   - phase_shift(): XOR map from LFSR state to one scan-chain input bit.
//     Chain i receives lfsr_q[i] ^ lfsr_q[n-i], which pairs taps from both
//     ends of the register so neighbouring chains are not shifted copies of
//     each other.
package lbist_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_UNLOAD  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Widest LFSR state the helper accepts; callers zero-extend into it.
    localparam int PS_MAX_W = 1024;

    // Returns scan_in bit for chain 'chain' of an LFSR whose MSB index is 'n'.
    function automatic logic phase_shift(input logic [PS_MAX_W-1:0] lfsr_q,
                                         input logic [9:0]          n,
                                         input logic [9:0]          chain);
        return lfsr_q[chain] ^ lfsr_q[n - chain];
    endfunction

endpackage

// File: rtl/lbist_phase_shifter.sv
// lbist_phase_shifter
//   Purely combinational phase shifter between the LFSR and the scan chains.
//   Ports:
//     lfsr_q   in   N+1         current LFSR state
//     scan_in  out  NUM_CHAINS  one stimulus bit per chain, 0-cycle latency
module lbist_phase_shifter #(
    parameter int N          = 286,
    parameter int NUM_CHAINS = 8
) (
    input  logic [N:0]            lfsr_q,
    output logic [NUM_CHAINS-1:0] scan_in
);
    import lbist_pkg::*;

    logic [PS_MAX_W-1:0] state_ext;

    assign state_ext = {{(PS_MAX_W-N-1){1'b0}}, lfsr_q};

    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
        assign scan_in[gi] = phase_shift(state_ext, 10'(N), 10'(gi));
    end

endmodule

// File: rtl/lbist_pattern_sequencer.sv
// lbist_pattern_sequencer
//   Turns LFSR state into scan stimulus and runs the shift/capture loop for
//   NUM_PATTERNS patterns, followed by one final unload, then reports done.
//   Ports:
//     clk          in   1        system clock, rising edge
//     reset_lfsr   in   1        asynchronous active-high reset (shared with LFSR)
//     start        in   1        session start pulse, honoured in IDLE/DONE only
//     lfsr_q       in   N+1      current LFSR state
//     lfsr_en      out  1        LFSR advance enable
//     scan_en      out  1        scan-shift enable to all chains
//     scan_in      out  NUM_CHAINS phase-shifted serial stimulus
//     capture      out  1        1-cycle functional capture strobe
//     misr_en      out  1        MISR compaction enable
//     pattern_cnt  out  clog2(NUM_PATTERNS)+1  patterns captured so far
//     busy         out  1        high in SHIFT, CAPTURE and UNLOAD
//     done         out  1        high in DONE
module lbist_pattern_sequencer #(
    parameter int N            = 286,
    parameter int NUM_CHAINS   = 8,
    parameter int CHAIN_LEN    = 36,
    parameter int NUM_PATTERNS = 1024
) (
    input  logic                            clk,
    input  logic                            reset_lfsr,
    input  logic                            start,
    input  logic [N:0]                      lfsr_q,
    output logic                            lfsr_en,
    output logic                            scan_en,
    output logic [NUM_CHAINS-1:0]           scan_in,
    output logic                            capture,
    output logic                            misr_en,
    output logic [$clog2(NUM_PATTERNS):0]   pattern_cnt,
    output logic                            busy,
    output logic                            done
);
    import lbist_pkg::*;

    localparam int SHIFT_W = $clog2(CHAIN_LEN);
    localparam int PCNT_W  = $clog2(NUM_PATTERNS) + 1;

    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
    localparam logic [PCNT_W-1:0]  PCNT_MAX   = PCNT_W'(NUM_PATTERNS);

    logic [2:0]         state_q, state_d;
    logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [PCNT_W-1:0]  pattern_cnt_q, pattern_cnt_d;

    lbist_phase_shifter #(
        .N          (N),
        .NUM_CHAINS (NUM_CHAINS)
    ) u_phase_shifter (
        .lfsr_q  (lfsr_q),
        .scan_in (scan_in)
    );

    // State and counter registers.
    always_ff @(posedge clk or posedge reset_lfsr) begin
        if (reset_lfsr) begin
            state_q       <= ST_IDLE;
            shift_cnt_q   <= '0;
            pattern_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            shift_cnt_q   <= shift_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d       = state_q;
        shift_cnt_d   = shift_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_SHIFT;
                    shift_cnt_d   = '0;
                    pattern_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d     = ST_CAPTURE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                // The count becomes visible after the capture cycle; the exit
                // decision looks at the post-increment value.
                if (pattern_cnt_q != PCNT_MAX) begin
                    pattern_cnt_d = pattern_cnt_q + 1'b1;
                end
                shift_cnt_d = '0;
                if (pattern_cnt_q + 1'b1 == PCNT_MAX) begin
                    state_d = ST_UNLOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_UNLOAD: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d     = ST_DONE;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                shift_cnt_d   = '0;
                pattern_cnt_d = '0;
            end
        endcase
    end

    // Moore output decode from registered state only.
    always_comb begin
        lfsr_en = 1'b0;
        scan_en = 1'b0;
        capture = 1'b0;
        misr_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                lfsr_en = 1'b1;
                scan_en = 1'b1;
                busy    = 1'b1;
                // The very first load has no captured response to compact.
                misr_en = (pattern_cnt_q != '0);
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                busy    = 1'b1;
            end
            ST_UNLOAD: begin
                scan_en = 1'b1;
                misr_en = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pattern_cnt = pattern_cnt_q;

endmodule

// File: tb/tb_lbist_pattern_sequencer.sv
// tb_lbist_pattern_sequencer
//   Drives the sequencer from a small 8-bit LFSR and compares every cycle
//   against a reference model that derives the expected outputs from the
//   number of cycles elapsed since the accepted start pulse.
module tb_lbist_pattern_sequencer;

    localparam int N       = 7;
    localparam int NC      = 4;
    localparam int CL      = 4;
    localparam int NP      = 3;
    localparam int PCW     = $clog2(NP) + 1;
    localparam int LOOP    = NP * (CL + 1);
    localparam int SESSION = LOOP + CL;

    logic           clk = 1'b0;
    logic           reset_lfsr;
    logic           start;
    logic [N:0]     lfsr_q;
    logic [N:0]     lfsr_reg;
    logic [N:0]     force_val;
    logic           force_en;
    logic           lfsr_en;
    logic           scan_en;
    logic [NC-1:0]  scan_in;
    logic           capture;
    logic           misr_en;
    logic [PCW-1:0] pattern_cnt;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 running (t = cycles since start edge), 2 done.
    int mode = 0;
    int t    = 0;

    always #5 clk = ~clk;

    // Environment LFSR (x^8+x^6+x^5+x^4), advances only when enabled.
    always_ff @(posedge clk or posedge reset_lfsr) begin
        if (reset_lfsr) lfsr_reg <= 8'h01;
        else if (lfsr_en) lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & 8'hB8)};
    end

    assign lfsr_q = force_en ? force_val : lfsr_reg;

    lbist_pattern_sequencer #(
        .N            (N),
        .NUM_CHAINS   (NC),
        .CHAIN_LEN    (CL),
        .NUM_PATTERNS (NP)
    ) dut (
        .clk         (clk),
        .reset_lfsr  (reset_lfsr),
        .start       (start),
        .lfsr_q      (lfsr_q),
        .lfsr_en     (lfsr_en),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .capture     (capture),
        .misr_en     (misr_en),
        .pattern_cnt (pattern_cnt),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (mode=%0d t=%0d time=%0t)",
                     tag, got, exp, mode, t, $time);
        end
    endtask

    task automatic check_all();
        logic          e_sh, e_cap, e_un, e_misr, e_busy, e_done;
        int            e_pc, p, k;
        logic [NC-1:0] e_si;
        e_sh = 0; e_cap = 0; e_un = 0; e_misr = 0; e_busy = 0; e_done = 0;
        e_pc = 0;
        if (mode == 2) begin
            e_done = 1;
            e_pc   = NP;
        end else if (mode == 1) begin
            e_busy = 1;
            if (t < LOOP) begin
                p    = t / (CL + 1);
                k    = t % (CL + 1);
                e_pc = p;
                if (k < CL) begin
                    e_sh   = 1;
                    e_misr = (p != 0);
                end else begin
                    e_cap = 1;
                end
            end else begin
                e_un = 1;
                e_pc = NP;
            end
        end
        for (int i = 0; i < NC; i++) e_si[i] = lfsr_q[i] ^ lfsr_q[N-i];
        chk("lfsr_en",     32'(lfsr_en),     32'(e_sh));
        chk("scan_en",     32'(scan_en),     32'(e_sh | e_un));
        chk("capture",     32'(capture),     32'(e_cap));
        chk("misr_en",     32'(misr_en),     32'(e_misr | e_un));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("done",        32'(done),        32'(e_done));
        chk("pattern_cnt", 32'(pattern_cnt), 32'(e_pc));
        chk("scan_in",     32'(scan_in),     32'(e_si));
        $display("cyc mode=%0d t=%0d start=%0b busy=%0b done=%0b cap=%0b pcnt=%0d scan_in=%h",
                 mode, t, start, busy, done, capture, pattern_cnt, scan_in);
    endtask

    // One clock: drive start, advance the model at the edge, check after it.
    task automatic tick(input logic st);
        start = st;
        @(posedge clk);
        if (reset_lfsr) begin
            mode = 0;
        end else if (mode != 1) begin
            if (st) begin
                mode = 1;
                t    = 0;
            end
        end else begin
            t++;
            if (t == SESSION) mode = 2;
        end
        #1;
        start = 1'b0;
        check_all();
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic reset_mid();
        #2;
        reset_lfsr = 1'b1;
        mode       = 0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        reset_lfsr = 1'b0;
    endtask

    // Counts edges from an accepted start until done is seen.
    task automatic run_to_done(input int pulse_at);
        int cyc;
        tick(1'b1);
        cyc = 0;
        while (!done && cyc < 40) begin
            cyc++;
            tick(cyc == pulse_at);
        end
        chk("done_latency", 32'(cyc), 32'(SESSION));
    endtask

    // Protocol invariants sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_lfsr) begin
            chk("inv_capture_and_scan", 32'(capture & scan_en), 32'd0);
            chk("inv_misr_no_scan",     32'(misr_en & ~scan_en), 32'd0);
            chk("inv_lfsr_en_no_scan",  32'(lfsr_en & ~scan_en), 32'd0);
            chk("inv_lfsr_en_done",     32'(lfsr_en & done),     32'd0);
        end
    end

    initial begin
        reset_lfsr = 1'b1;
        start      = 1'b0;
        force_en   = 1'b0;
        force_val  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3;
        reset_lfsr = 1'b0;

        // Idle with no start, then a full session.
        tick(1'b0);
        tick(1'b0);
        run_to_done(0);
        repeat (3) tick(1'b0);

        // Restart from DONE; start re-pulsed during shift of pattern 2 is ignored.
        run_to_done(7);
        tick(1'b0);

        // Phase shifter: 0-cycle response to forced LFSR values.
        force_en  = 1'b1;
        force_val = 8'b1000_0001;
        #1;
        chk("ps_81", 32'(scan_in), 32'h0);
        force_val = 8'b0000_0001;
        #1;
        chk("ps_01", 32'(scan_in), 32'h1);
        repeat (6) begin
            force_val = 8'($urandom_range(0, 255));
            #1;
            check_all();
        end
        force_en = 1'b0;

        // Reset in the middle of the first CAPTURE cycle.
        tick(1'b1);
        repeat (CL) tick(1'b0);
        chk("at_capture", 32'(capture), 32'd1);
        reset_mid();
        repeat (8) tick(1'b0);

        // Random start pulses and occasional resets.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 59) == 0) reset_mid();
            else tick($urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
